// File: rtl/vga_rect_fill_ctrl.sv
// Rectangle-fill sequencer for port A of the 160x120 1bpp VGA frame buffer.
// The CPU programs origin, size and pixel value, then starts a clipped, row-major fill.
module vga_rect_fill_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'hB8,
  parameter int         H_PIXELS  = 160,
  parameter int         V_PIXELS  = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  inout  wire  [7:0]  BUS_DATA,
  input  logic [7:0]  BUS_ADDR,
  input  logic        BUS_WE,
  input  logic        VGA_VS,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  output logic        BUSY,
  output logic        IRQ_DONE
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_FILL    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] A_X0    = BASE_ADDR;
  localparam logic [7:0] A_Y0    = BASE_ADDR + 8'd1;
  localparam logic [7:0] A_W     = BASE_ADDR + 8'd2;
  localparam logic [7:0] A_H     = BASE_ADDR + 8'd3;
  localparam logic [7:0] A_CTRL  = BASE_ADDR + 8'd4;
  localparam logic [7:0] A_START = BASE_ADDR + 8'd5;
  localparam logic [8:0] H_LIM   = 9'(H_PIXELS);
  localparam logic [8:0] V_LIM   = 9'(V_PIXELS);

  state_t      state, next_state;

  // Programmed copies, written by the CPU at any time
  logic [7:0]  x0_reg, w_reg;
  logic [6:0]  y0_reg, h_reg;
  logic [1:0]  ctrl_reg;

  // Working copies, captured when a START is accepted
  logic [7:0]  x0_w, wc_w, cx;
  logic [6:0]  y0_w, hc_w, cy;
  logic        pix_w;

  logic        vs_q;
  logic        sticky;

  logic        start_wr, vs_fall, row_end, last_px;
  logic [8:0]  rem_w, rem_h, wc_c, hc_c;
  logic        fill_empty;

  assign start_wr = BUS_WE && (BUS_ADDR == A_START);
  assign vs_fall  = vs_q && !VGA_VS;
  assign row_end  = (cx == wc_w - 8'd1);
  assign last_px  = row_end && (cy == hc_w - 7'd1);

  // 9-bit clip arithmetic; an out-of-range origin is caught by fill_empty
  // before the wrapped remainder could matter.
  assign rem_w      = H_LIM - {1'b0, x0_reg};
  assign rem_h      = V_LIM - {2'b00, y0_reg};
  assign wc_c       = ({1'b0, w_reg} < rem_w)  ? {1'b0, w_reg}  : rem_w;
  assign hc_c       = ({2'b00, h_reg} < rem_h) ? {2'b00, h_reg} : rem_h;
  assign fill_empty = ({1'b0, x0_reg} >= H_LIM) || ({2'b00, y0_reg} >= V_LIM) ||
                      (wc_c == 9'd0) || (hc_c == 9'd0);

  assign BUSY     = (state == ST_WAIT_VS) || (state == ST_FILL);
  assign BUS_DATA = (!BUS_WE && (BUS_ADDR == A_START)) ? {6'b0, sticky, BUSY} : 8'hzz;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_wr) begin
          if (fill_empty)       next_state = ST_DONE;
          else if (ctrl_reg[1]) next_state = ST_WAIT_VS;
          else                  next_state = ST_FILL;
        end
      end
      ST_WAIT_VS: if (vs_fall) next_state = ST_FILL;
      ST_FILL:    if (last_px) next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x0_reg   <= '0;
      y0_reg   <= '0;
      w_reg    <= '0;
      h_reg    <= '0;
      ctrl_reg <= '0;
      x0_w     <= '0;
      y0_w     <= '0;
      wc_w     <= '0;
      hc_w     <= '0;
      pix_w    <= 1'b0;
      cx       <= '0;
      cy       <= '0;
      vs_q     <= 1'b0;
      sticky   <= 1'b0;
      FB_ADDR  <= '0;
      FB_DATA  <= 1'b0;
      FB_WE    <= 1'b0;
      IRQ_DONE <= 1'b0;
    end else begin
      vs_q <= VGA_VS;

      if (BUS_WE && BUS_ADDR == A_X0)   x0_reg   <= BUS_DATA;
      if (BUS_WE && BUS_ADDR == A_Y0)   y0_reg   <= BUS_DATA[6:0];
      if (BUS_WE && BUS_ADDR == A_W)    w_reg    <= BUS_DATA;
      if (BUS_WE && BUS_ADDR == A_H)    h_reg    <= BUS_DATA[6:0];
      if (BUS_WE && BUS_ADDR == A_CTRL) ctrl_reg <= BUS_DATA[1:0];

      if (state == ST_IDLE && start_wr) begin
        x0_w   <= x0_reg;
        y0_w   <= y0_reg;
        wc_w   <= wc_c[7:0];
        hc_w   <= hc_c[6:0];
        pix_w  <= ctrl_reg[0];
        cx     <= '0;
        cy     <= '0;
        sticky <= 1'b0;
      end

      if (state == ST_FILL) begin
        if (row_end) begin
          cx <= '0;
          cy <= cy + 7'd1;
        end else begin
          cx <= cx + 8'd1;
        end
        FB_ADDR <= {y0_w + cy, x0_w + cx};
        FB_DATA <= pix_w;
      end

      FB_WE    <= (state == ST_FILL);
      IRQ_DONE <= (state == ST_DONE);
      if (state == ST_DONE) sticky <= 1'b1;
    end
  end

endmodule
